// File: rtl/pet_stats_engine.sv
// Pet stats engine: N saturating stat counters with tick-divided random decay,
// a valid/ready command port and an ALIVE/SLEEPING/DEAD life-cycle FSM.
module pet_stats_engine #(
    parameter int N_STATS    = 4,
    parameter int STAT_W     = 5,
    parameter int TICK_DIV   = 4,
    parameter int BOOST      = 8,
    parameter int SLEEP_CH   = 3,
    parameter int LOW_THRESH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [7:0]                  rand_in,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [2:0]                  cmd_chan,
    output logic [N_STATS*STAT_W-1:0]   stats_flat,
    output logic [N_STATS-1:0]          low_flags,
    output logic                        is_sleeping,
    output logic                        is_dead,
    output logic                        cmd_err
);

    localparam int MAX   = 2**STAT_W - 1;
    localparam int SW    = STAT_W + 3;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic signed [SW-1:0] ONE_S  = SW'(1);
    localparam logic signed [SW-1:0] TWO_S  = SW'(2);
    localparam logic signed [SW-1:0] BST_S  = SW'(BOOST);
    localparam logic signed [SW-1:0] MAX_S  = SW'(MAX);
    localparam logic signed [SW-1:0] ZERO_S = '0;

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SLEEPING = 2'd1,
        DEAD     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [STAT_W-1:0]   stat_q [N_STATS];
    logic [STAT_W-1:0]   stat_d [N_STATS];
    logic signed [SW-1:0] sum  [N_STATS];
    logic [DIV_W-1:0]    div_q, div_d;
    logic                ready_q;
    logic                err_q, err_d;

    logic accept, is_boost, is_sleep, is_rev;
    logic chan_ok, boost_ok, revive_ok, step;
    logic [3:0] n_zero;
    logic two_zero;
    logic unused_rand;

    assign unused_rand = ^rand_in;

    always_comb begin
        accept   = cmd_valid && ready_q;
        is_boost = 1'b0;
        is_sleep = 1'b0;
        is_rev   = 1'b0;
        unique case (cmd_op)
            2'b00:   is_boost = accept;
            2'b01:   is_sleep = accept;
            2'b10:   is_rev   = accept;
            default: ;
        endcase
        chan_ok   = int'(cmd_chan) < N_STATS;
        boost_ok  = is_boost && (state_q == ALIVE) && chan_ok;
        revive_ok = is_rev && (state_q == DEAD);
        err_d     = (is_boost && !boost_ok)
                 || (is_sleep && state_q == DEAD)
                 || (is_rev && !revive_ok);
        step      = tick && (div_q == DIV_W'(TICK_DIV - 1));
    end

    always_comb begin
        div_d = div_q;
        if (revive_ok || step) begin
            div_d = '0;
        end else if (tick) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // dec, cost and inc are summed wide first so the clamp is applied once
    always_comb begin
        n_zero = '0;
        for (int i = 0; i < N_STATS; i++) begin
            sum[i] = $signed({3'b000, stat_q[i]});
            if (step && state_q != DEAD && rand_in[i]
                && !(state_q == SLEEPING && i == SLEEP_CH)) begin
                sum[i] = sum[i] - ONE_S;
            end
            if (step && state_q == SLEEPING && i == SLEEP_CH) begin
                sum[i] = sum[i] + TWO_S;
            end
            if (boost_ok && int'(cmd_chan) == i) begin
                sum[i] = sum[i] + BST_S;
            end
            if (boost_ok && int'(cmd_chan) != SLEEP_CH && i == SLEEP_CH) begin
                sum[i] = sum[i] - ONE_S;
            end
            if (sum[i] < ZERO_S) begin
                stat_d[i] = '0;
            end else if (sum[i] > MAX_S) begin
                stat_d[i] = STAT_W'(MAX);
            end else begin
                stat_d[i] = sum[i][STAT_W-1:0];
            end
            if (revive_ok) begin
                stat_d[i] = STAT_W'(MAX);
            end
            n_zero = n_zero + 4'(stat_d[i] == '0);
        end
        two_zero = n_zero >= 4'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ALIVE;
            div_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_STATS; i++) begin
                stat_q[i] <= STAT_W'(MAX);
            end
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ready_q <= 1'b1;
            err_q   <= err_d;
            for (int i = 0; i < N_STATS; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    // death is checked last so it overrides a wake in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ALIVE: begin
                if (is_sleep) state_d = SLEEPING;
            end
            SLEEPING: begin
                if (is_sleep || stat_d[SLEEP_CH] == STAT_W'(MAX)) begin
                    state_d = ALIVE;
                end
            end
            DEAD: begin
                if (revive_ok) state_d = ALIVE;
            end
            default: state_d = ALIVE;
        endcase
        if (state_q != DEAD && two_zero) begin
            state_d = DEAD;
        end
    end

    always_comb begin
        is_sleeping = state_q == SLEEPING;
        is_dead     = state_q == DEAD;
        cmd_ready   = ready_q;
        cmd_err     = err_q;
        low_flags   = '0;
        stats_flat  = '0;
        for (int i = 0; i < N_STATS; i++) begin
            low_flags[i] = (state_q != DEAD)
                        && (stat_q[i] < STAT_W'(LOW_THRESH));
            stats_flat[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end

endmodule

// File: doc/pet_stats_engine.md
Name: pet_stats_engine

Overview:
Parametrised successor to the fixed four-stat pet stats logic. It holds N_STATS saturating stat counters of STAT_W bits and decays them on a divided second tick, gated by random bits. It accepts user commands over a valid/ready handshake and runs an ALIVE/SLEEPING/DEAD state machine. It sits between the UART command decoder and the display/report path, taking the 1 Hz `second` pulse and the LFSR byte.

Parameters:
N_STATS, 4, number of stat channels (2..8)
STAT_W, 5, stat width; MAX = 2^STAT_W-1
TICK_DIV, 4, seconds per decay step (>=1)
BOOST, 8, amount added by a boost command
SLEEP_CH, 3, index of the energy channel
LOW_THRESH, 4, stat < LOW_THRESH raises its low flag

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle pulse per second
rand_in  in  8  random byte from LFSR
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_op  in  2  00 boost, 01 sleep, 10 revive, 11 nop
cmd_chan  in  3  target channel for boost
stats_flat  out  N_STATS*STAT_W  channel i at bits [i*STAT_W +: STAT_W]
low_flags  out  N_STATS  per-channel low indicator
is_sleeping  out  1  state==SLEEPING
is_dead  out  1  state==DEAD
cmd_err  out  1  one-cycle pulse on a dropped command

Behaviour:
- Reset (async, active-high):
  - every stat = MAX; state ALIVE; tick divider = 0.
  - cmd_ready = 0 while reset is high, then 1 from the first clk edge after release.
  - cmd_err = 0; low_flags = 0.
- All outputs are registered, except low_flags, is_sleeping and is_dead, which decode registered state directly.
- Divider:
  - counts tick pulses 0..TICK_DIV-1.
  - A tick arriving at TICK_DIV-1 wraps the divider to 0 and produces a decay step in that same cycle.
  - Takes effect on the next edge; no other latency.
- Decay step:
  - ALIVE: channel i loses 1 when rand_in[i] = 1, and 0 otherwise.
  - SLEEPING: every non-SLEEP_CH channel decays the same way. SLEEP_CH gains 2 and ignores rand_in.
  - DEAD: no decay.
- Command accepted when cmd_valid && cmd_ready; cmd_ready is 1 in every state after reset.
  - Boost, ALIVE, cmd_chan < N_STATS: stat[cmd_chan] += BOOST.
    - If cmd_chan != SLEEP_CH, energy also loses 1 (play costs energy).
    - If cmd_chan == SLEEP_CH, no energy cost.
  - Sleep, ALIVE: go to SLEEPING.
  - Sleep, SLEEPING: go to ALIVE (manual wake).
  - Revive, DEAD: all stats = MAX, divider = 0, go to ALIVE.
  - Nop: no effect, no error.
  - Dropped commands pulse cmd_err for one cycle and change nothing:
    - boost while SLEEPING or DEAD;
    - boost with cmd_chan >= N_STATS;
    - sleep while DEAD;
    - revive while not DEAD.
- Arithmetic:
  - Per-channel next value = stat - dec - cost + inc, computed signed in STAT_W+3 bits, then clamped to [0, MAX].
  - dec, cost and inc from the same cycle combine into a single update, so saturation is applied once.
- Transitions, evaluated on the post-update values:
  - SLEEPING to ALIVE automatically when SLEEP_CH reaches MAX.
  - ALIVE or SLEEPING to DEAD when two or more channels are 0. DEAD takes priority over any wake in the same cycle.
- Simultaneous events:
  - A sleep command in the same cycle as a decay step: the decay uses the pre-command state, and the state change applies after.
  - Reset mid-operation, in any state, returns to the full reset values immediately.
- low_flags[i] = stat[i] < LOW_THRESH; forced to 0 while DEAD.

Test Plan:
1. Reset pulse -> every stat = 31, is_sleeping = 0, is_dead = 0, cmd_ready = 1 one cycle after release, low_flags = 0.
2. rand_in = 8'h05, 4 tick pulses -> stats {ch0 30, ch1 31, ch2 30, ch3 31}. A further 3 ticks leave them unchanged, and the 8th tick gives ch0 29.
3. From energy 20, ch1 28: boost ch1 -> ch1 31 (saturated), energy 19. Boost cmd_chan = 5 -> cmd_err pulse, no change.
4. Sleep with energy 25, rand_in = 0:
   - 3 decay steps -> energy 27, 29, 31; auto-wake after the third, is_sleeping = 0.
   - Boost while sleeping -> cmd_err.
5. rand_in = 8'h03, repeated steps -> ch0 and ch1 hit 0 and is_dead = 1. Further ticks freeze the stats. Revive -> all 31, ALIVE.
6. Boost ch0 (at 10) in the same cycle as a decay step with rand_in[0] = 1 -> ch0 = 17, energy reduced by its decay plus 1. Assert reset while SLEEPING -> all 31, ALIVE.
